// File: rtl/link_channel_mux.sv
// Merges CHANNEL_NUM router output channels onto one link: wormhole locking,
// round-robin head arbitration and per-link-VC credit counting.
module link_channel_mux #(
  parameter int CHANNEL_NUM  = 2,
  parameter int VC_NUM       = 2,
  parameter int FLIT_WIDTH   = 64,
  parameter int CREDIT_DEPTH = 8,
  localparam int VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int LINK_VC_NUM = CHANNEL_NUM * VC_NUM,
  localparam int LINK_VC_W   = (LINK_VC_NUM > 1) ? $clog2(LINK_VC_NUM) : 1,
  localparam int CH_W        = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1,
  localparam int CNT_W       = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CHANNEL_NUM-1:0]                ch_valid_i,
  input  logic [CHANNEL_NUM-1:0][FLIT_WIDTH-1:0] ch_data_i,
  input  logic [CHANNEL_NUM-1:0]                ch_head_i,
  input  logic [CHANNEL_NUM-1:0]                ch_tail_i,
  input  logic [CHANNEL_NUM-1:0][VC_W-1:0]      ch_vc_i,
  output logic [CHANNEL_NUM-1:0]                ch_ready_o,
  output logic                                  link_valid_o,
  output logic                                  link_head_o,
  output logic                                  link_tail_o,
  output logic [FLIT_WIDTH-1:0]                 link_data_o,
  output logic [LINK_VC_W-1:0]                  link_vc_o,
  input  logic                                  credit_valid_i,
  input  logic [LINK_VC_W-1:0]                  credit_vc_i,
  output logic [1:0]                            error_o
);

  // Handshake: a flit on channel c moves when ch_valid_i[c] && ch_ready_o[c];
  // ready is a one-hot grant computed from registered state and channel inputs.
  logic [CH_W-1:0]        rr_ptr;
  logic                   lock_valid;
  logic [CH_W-1:0]        lock_owner;
  logic [CNT_W-1:0]       credit_cnt [LINK_VC_NUM];

  logic [LINK_VC_W-1:0]   ch_link_vc [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] eligible;
  logic [CHANNEL_NUM-1:0] proto_err;
  logic                   grant_valid;
  logic [CH_W-1:0]        grant_ch;
  logic [CH_W-1:0]        scan_ch;
  logic [LINK_VC_W-1:0]   grant_vc;
  logic                   grant_head;
  logic                   grant_tail;
  logic [LINK_VC_NUM-1:0] credit_send;
  logic [LINK_VC_NUM-1:0] credit_ret;
  logic                   credit_overflow;

  always_comb begin
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      ch_link_vc[c] = LINK_VC_W'(c * VC_NUM + int'(ch_vc_i[c]));
      eligible[c]   = ch_valid_i[c] && (credit_cnt[ch_link_vc[c]] != '0) &&
                      ((!lock_valid && ch_head_i[c]) ||
                       (lock_valid && lock_owner == CH_W'(c)));
      // A body/tail flit is only legal from the channel holding the lock.
      proto_err[c]  = ch_valid_i[c] && !ch_head_i[c] &&
                      !(lock_valid && lock_owner == CH_W'(c));
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    scan_ch     = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      scan_ch = CH_W'((int'(rr_ptr) + i) % CHANNEL_NUM);
      if (!grant_valid && eligible[scan_ch]) begin
        grant_valid = 1'b1;
        grant_ch    = scan_ch;
      end
    end
    if (rst) grant_valid = 1'b0;
    grant_vc   = ch_link_vc[grant_ch];
    grant_head = ch_head_i[grant_ch];
    grant_tail = ch_tail_i[grant_ch];
    for (int c = 0; c < CHANNEL_NUM; c++)
      ch_ready_o[c] = grant_valid && (grant_ch == CH_W'(c));
  end

  always_comb begin
    credit_overflow = 1'b0;
    for (int v = 0; v < LINK_VC_NUM; v++) begin
      credit_send[v] = grant_valid && (grant_vc == LINK_VC_W'(v));
      credit_ret[v]  = credit_valid_i && (credit_vc_i == LINK_VC_W'(v));
      if (credit_ret[v] && !credit_send[v] && credit_cnt[v] == CNT_W'(CREDIT_DEPTH))
        credit_overflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      link_valid_o <= 1'b0;
      link_head_o  <= 1'b0;
      link_tail_o  <= 1'b0;
      link_data_o  <= '0;
      link_vc_o    <= '0;
      error_o      <= '0;
      rr_ptr       <= '0;
      lock_valid   <= 1'b0;
      lock_owner   <= '0;
      for (int v = 0; v < LINK_VC_NUM; v++) credit_cnt[v] <= CNT_W'(CREDIT_DEPTH);
    end else begin
      link_valid_o <= grant_valid;
      link_head_o  <= grant_valid && grant_head;
      link_tail_o  <= grant_valid && grant_tail;
      if (grant_valid) begin
        link_data_o <= ch_data_i[grant_ch];
        link_vc_o   <= grant_vc;
        if (grant_head)
          rr_ptr <= CH_W'((int'(grant_ch) + 1) % CHANNEL_NUM);
        // Single-flit packets pass through without touching the lock.
        if (grant_head && !grant_tail) begin
          lock_valid <= 1'b1;
          lock_owner <= grant_ch;
        end else if (grant_tail && lock_valid && lock_owner == grant_ch) begin
          lock_valid <= 1'b0;
        end
      end
      for (int v = 0; v < LINK_VC_NUM; v++) begin
        if (credit_send[v] && !credit_ret[v])
          credit_cnt[v] <= credit_cnt[v] - 1'b1;
        else if (credit_ret[v] && !credit_send[v] && credit_cnt[v] != CNT_W'(CREDIT_DEPTH))
          credit_cnt[v] <= credit_cnt[v] + 1'b1;
      end
      error_o[0] <= error_o[0] | credit_overflow;
      error_o[1] <= error_o[1] | (|proto_err);
    end
  end

endmodule

// File: tb/tb_link_channel_mux.sv
// Directed and randomized checks of link_channel_mux against a flit-level
// reference model (credits, lock owner, round-robin pointer as plain integers).
module tb_link_channel_mux;
  localparam int N = 2, V = 2, W = 64, D = 8, LV = N * V, VCW = 1, LVW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]          ch_valid_i, ch_head_i, ch_tail_i, ch_ready_o;
  logic [N-1:0][W-1:0]   ch_data_i;
  logic [N-1:0][VCW-1:0] ch_vc_i;
  logic                  link_valid_o, link_head_o, link_tail_o;
  logic [W-1:0]          link_data_o;
  logic [LVW-1:0]        link_vc_o;
  logic                  credit_valid_i;
  logic [LVW-1:0]        credit_vc_i;
  logic [1:0]            error_o;

  link_channel_mux #(.CHANNEL_NUM(N), .VC_NUM(V), .FLIT_WIDTH(W), .CREDIT_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .ch_valid_i(ch_valid_i), .ch_data_i(ch_data_i),
    .ch_head_i(ch_head_i), .ch_tail_i(ch_tail_i), .ch_vc_i(ch_vc_i),
    .ch_ready_o(ch_ready_o), .link_valid_o(link_valid_o), .link_head_o(link_head_o),
    .link_tail_o(link_tail_o), .link_data_o(link_data_o), .link_vc_o(link_vc_o),
    .credit_valid_i(credit_valid_i), .credit_vc_i(credit_vc_i), .error_o(error_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  int           m_cred [LV];
  int           m_lock;
  int           m_rr;
  logic [1:0]   m_err;
  logic         m_lv, m_lh, m_lt, m_rst_seen;
  logic [W-1:0] m_ld;
  int           m_lvc;

  int           vectors, miscompares;
  logic [N-1:0] last_acc;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lv_of(input int c);
    return c * V + int'(ch_vc_i[c]);
  endfunction

  function automatic bit elig(input int c);
    return ch_valid_i[c] && m_cred[lv_of(c)] > 0 &&
           ((m_lock < 0 && ch_head_i[c]) || m_lock == c);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < LV; v++) m_cred[v] = D;
    m_lock = -1; m_rr = 0; m_err = '0;
    m_lv = 0; m_lh = 0; m_lt = 0; m_ld = '0; m_lvc = 0;
  endtask

  task automatic model_update(input int g);
    int sv, rv;
    for (int c = 0; c < N; c++)
      if (ch_valid_i[c] && !ch_head_i[c] && m_lock != c) m_err[1] = 1'b1;
    sv = -1;
    m_lv = (g >= 0);
    m_lh = 0; m_lt = 0;
    if (g >= 0) begin
      sv = lv_of(g);
      m_lh = ch_head_i[g]; m_lt = ch_tail_i[g]; m_ld = ch_data_i[g]; m_lvc = sv;
      if (ch_head_i[g]) m_rr = (g + 1) % N;
      if (ch_head_i[g] && !ch_tail_i[g]) m_lock = g;
      else if (ch_tail_i[g] && m_lock == g) m_lock = -1;
    end
    rv = credit_valid_i ? int'(credit_vc_i) : -1;
    if (rv >= 0 && rv != sv) begin
      if (m_cred[rv] == D) m_err[0] = 1'b1;
      else m_cred[rv]++;
    end
    if (sv >= 0 && rv != sv) m_cred[sv]--;
  endtask

  // One clock: inputs were set at the preceding negedge.
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    #1;
    g = -1;
    if (!rst)
      for (int i = 0; i < N; i++)
        if (g < 0 && elig((m_rr + i) % N)) g = (m_rr + i) % N;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("ready", ch_ready_o, er);
    last_acc = ch_ready_o;
    @(posedge clk);
    m_rst_seen = rst;
    if (rst) model_reset();
    else model_update(g);
    #1;
    chk("link_valid", link_valid_o, m_lv);
    if (m_lv || m_rst_seen) begin
      chk("link_head", link_head_o, m_lh);
      chk("link_tail", link_tail_o, m_lt);
      chk("link_data", link_data_o, m_ld);
      chk("link_vc", link_vc_o, m_lvc);
    end
    chk("error", error_o, m_err);
    @(negedge clk);
  endtask

  task automatic set_idle();
    ch_valid_i = '0; ch_head_i = '0; ch_tail_i = '0; ch_vc_i = '0;
    ch_data_i = '0; credit_valid_i = 1'b0; credit_vc_i = '0;
  endtask

  task automatic drive_ret();
    credit_valid_i = link_valid_o;
    credit_vc_i    = link_vc_o;
  endtask

  task automatic rand_data();
    for (int c = 0; c < N; c++) ch_data_i[c] = {$urandom(), $urandom()};
  endtask

  int p, cnt, acc1;
  int r_len [N];
  int r_pos [N];
  int r_vc  [N];

  initial begin
    vectors = 0; miscompares = 0; last_acc = '0;
    set_idle();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b0;

    // Two channels of single-flit packets on VC0: strict alternation.
    for (int k = 0; k < 10; k++) begin
      ch_valid_i = '1; ch_head_i = '1; ch_tail_i = '1; ch_vc_i = '0;
      rand_data(); drive_ret();
      cycle();
      chk("alternate", last_acc, (k % 2 == 0) ? 2'b01 : 2'b10);
    end

    // ch0 4-flit packet holds the link while ch1 keeps offering a head.
    set_idle(); p = 0;
    for (int k = 0; k < 12; k++) begin
      ch_valid_i[0] = (p < 4); ch_head_i[0] = (p == 0); ch_tail_i[0] = (p == 3);
      ch_vc_i[0] = '0;
      ch_valid_i[1] = 1'b1; ch_head_i[1] = 1'b1; ch_tail_i[1] = 1'b1; ch_vc_i[1] = '0;
      rand_data(); drive_ret();
      cycle();
      if (last_acc[0] && p < 4) p++;
    end
    chk("pkt_done", p, 4);
    set_idle(); drive_ret(); cycle();

    // Credit exhaustion on link VC1, then a single returned credit.
    set_idle(); cnt = 0;
    for (int k = 0; k < 12; k++) begin
      ch_valid_i[0] = 1'b1; ch_head_i[0] = 1'b1; ch_tail_i[0] = 1'b1; ch_vc_i[0] = 1'b1;
      rand_data();
      cycle();
      if (link_valid_o && link_vc_o == 2'd1) cnt++;
    end
    chk("vc1_sent8", cnt, 8);
    chk("vc1_stalled", ch_ready_o, 2'b00);
    credit_valid_i = 1'b1; credit_vc_i = 2'd1; cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      credit_valid_i = 1'b0;
      if (link_valid_o && link_vc_o == 2'd1) cnt++;
    end
    chk("vc1_one_more", cnt, 1);

    // Return on a full counter sets the sticky overflow bit; depth unchanged.
    set_idle();
    credit_valid_i = 1'b1; credit_vc_i = 2'd3;
    cycle();
    chk("overflow_err", error_o[0], 1'b1);
    credit_valid_i = 1'b0; cnt = 0;
    for (int k = 0; k < 12; k++) begin
      ch_valid_i[1] = 1'b1; ch_head_i[1] = 1'b1; ch_tail_i[1] = 1'b1; ch_vc_i[1] = 1'b1;
      rand_data();
      cycle();
      if (link_valid_o && link_vc_o == 2'd3) cnt++;
    end
    chk("vc3_sent8", cnt, 8);
    chk("overflow_sticky", error_o[0], 1'b1);

    // Body flit without lock on ch1: never granted, ch0 flows on.
    set_idle(); cnt = 0; acc1 = 0;
    for (int k = 0; k < 6; k++) begin
      ch_valid_i = '1; ch_head_i = 2'b01; ch_tail_i = 2'b01; ch_vc_i = '0;
      rand_data(); drive_ret();
      cycle();
      if (last_acc[0]) cnt++;
      if (last_acc[1]) acc1++;
    end
    chk("proto_ch0_flow", cnt, 6);
    chk("proto_ch1_blocked", acc1, 0);
    chk("proto_err", error_o[1], 1'b1);
    set_idle(); drive_ret(); cycle();

    // Reset mid-packet with ch0 holding the lock and 3 credits left on VC0.
    set_idle(); p = 0;
    for (int k = 0; k < 10 && p < 5; k++) begin
      ch_valid_i[0] = 1'b1; ch_head_i[0] = (p == 0); ch_tail_i[0] = 1'b0; ch_vc_i[0] = '0;
      rand_data();
      cycle();
      if (last_acc[0]) p++;
    end
    chk("pre_rst_flits", p, 5);
    ch_valid_i = 2'b11; ch_head_i = 2'b10; ch_tail_i = '0; ch_vc_i = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_err_clear", error_o, 2'b00);
    ch_valid_i = 2'b10; rand_data();
    cycle();
    chk("post_rst_grant", last_acc, 2'b10);
    p = 1;
    for (int k = 0; k < 6 && p < 3; k++) begin
      ch_valid_i = 2'b10; ch_head_i = '0; ch_tail_i = {(p == 2), 1'b0};
      rand_data();
      cycle();
      if (last_acc[1]) p++;
    end
    chk("post_rst_pkt", p, 3);
    set_idle(); cnt = 0;
    for (int k = 0; k < 11; k++) begin
      ch_valid_i[0] = 1'b1; ch_head_i[0] = 1'b1; ch_tail_i[0] = 1'b1; ch_vc_i[0] = '0;
      rand_data();
      cycle();
      if (link_valid_o && link_vc_o == 2'd0) cnt++;
    end
    chk("post_rst_credits", cnt, 8);

    // Randomized, protocol-respecting traffic with random credit returns.
    set_idle();
    for (int c = 0; c < N; c++) begin r_len[c] = 0; r_pos[c] = 0; r_vc[c] = 0; end
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < N; c++) begin
        if (r_len[c] == 0) begin
          r_len[c] = $urandom_range(1, 4); r_pos[c] = 0; r_vc[c] = $urandom_range(0, V - 1);
        end
        ch_valid_i[c] = ($urandom_range(0, 9) < 7);
        ch_head_i[c]  = (r_pos[c] == 0);
        ch_tail_i[c]  = (r_pos[c] == r_len[c] - 1);
        ch_vc_i[c]    = VCW'(r_vc[c]);
      end
      rand_data();
      credit_valid_i = 1'b0; credit_vc_i = '0;
      if ($urandom_range(0, 9) < 6) begin
        int v;
        v = $urandom_range(0, LV - 1);
        if (m_cred[v] < D) begin credit_valid_i = 1'b1; credit_vc_i = LVW'(v); end
      end
      cycle();
      for (int c = 0; c < N; c++)
        if (last_acc[c]) begin
          r_pos[c]++;
          if (r_pos[c] == r_len[c]) r_len[c] = 0;
        end
    end

    set_idle(); cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/link_channel_mux.md
# link_channel_mux

Merges `CHANNEL_NUM` router output channels onto one physical inter-router link, with wormhole packet locking and credit-based per-VC flow control. Each channel/VC pair maps to its own downstream VC on the link, so the upstream router's per-channel on/off signalling becomes per-link-VC credit accounting. The block sits between a router's crossbar outputs for one direction (for example, the two east channels) and the link wires.

## Interface
Parameters:
- `CHANNEL_NUM`, 2, number of merged input channels (≥1)
- `VC_NUM`, 2, VCs per channel; link VCs = `CHANNEL_NUM*VC_NUM`
- `FLIT_WIDTH`, 64, flit payload bits
- `CREDIT_DEPTH`, 8, downstream buffer slots per link VC (≥1); counter width `$clog2(CREDIT_DEPTH+1)`

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset
- `ch_valid_i`  in  [CHANNEL_NUM]  flit offered on channel c
- `ch_data_i`  in  [CHANNEL_NUM][FLIT_WIDTH]  payload
- `ch_head_i`, `ch_tail_i`  in  [CHANNEL_NUM]  head/tail markers; both set means single-flit packet
- `ch_vc_i`  in  [CHANNEL_NUM][$clog2(VC_NUM)]  VC within channel
- `ch_ready_o`  out  [CHANNEL_NUM]  flit on c accepted this cycle
- `link_valid_o`, `link_head_o`, `link_tail_o`  out  1  registered link flit strobe and markers
- `link_data_o`  out  FLIT_WIDTH  registered payload
- `link_vc_o`  out  $clog2(CHANNEL_NUM*VC_NUM)  link VC = `c*VC_NUM + ch_vc_i[c]`
- `credit_valid_i`  in  1  one credit returned by downstream
- `credit_vc_i`  in  $clog2(CHANNEL_NUM*VC_NUM)  link VC of the returned credit
- `error_o`  out  2  sticky: [0] credit overflow, [1] body/tail flit without lock

## Operation
- Transfer on channel c when `ch_valid_i[c] && ch_ready_o[c]`. `ch_ready_o` is a combinational one-hot grant, or all zero.
- Eligibility of channel c: valid, and credit[link VC] > 0, and one of:
  - the lock is free and the flit is a head, or
  - the lock is held by c.
- Lock:
  - A head without tail granted → lock = c.
  - A tail granted from the lock owner → lock cleared.
  - A single-flit packet never sets the lock.
  - While locked, only the owner is eligible. If the owner stalls (no valid or no credit), the link idles.
- Arbitration: round-robin over eligible channels, starting at `rr_ptr`. On each head grant, `rr_ptr` = granted c + 1 (mod `CHANNEL_NUM`). Body and tail grants do not move `rr_ptr`.
- Credits: one counter per link VC, reset to `CREDIT_DEPTH`.
  - −1 on a send to that VC.
  - +1 on `credit_valid_i` for that VC.
  - Send and return on the same VC in the same cycle → counter unchanged.
  - Return while the counter equals `CREDIT_DEPTH` (with no same-VC send that cycle) → counter holds at `CREDIT_DEPTH`, `error_o[0]` set.
- Protocol error: a valid non-head flit on a channel that does not own the lock → never granted, and `error_o[1]` set. The channel stays stalled until the source withdraws the flit or `rst` is asserted.
- Error bits clear only on `rst`.

## Timing
- Latency: the flit is granted in cycle N and appears on `link_*_o` in cycle N+1 with `link_valid_o`=1. `link_valid_o`=0 in any cycle after no grant.
- Throughput: 1 flit/cycle.
- Credit return at N makes the credit usable for a grant at N+1. With `CREDIT_DEPTH`=1 and a 1-cycle return, a VC sends at most every other cycle.
- Send-side decrement is visible to eligibility in the next cycle. Two consecutive flits on a VC with 1 credit → second is not granted.
- Reset (any cycle, including mid-packet):
  - `link_valid_o`/head/tail=0, `link_data_o`=0, `link_vc_o`=0, `ch_ready_o`=0, `error_o`=0.
  - All credits = `CREDIT_DEPTH`, lock cleared, `rr_ptr`=0.
  - In-flight packet state is discarded.
- Outputs depend on registered state and current inputs only; no combinational path from `credit_valid_i` to `ch_ready_o`.

## Test plan
- Defaults, both channels offer single-flit packets to VC0 every cycle, credits returned each cycle → grants alternate ch0, ch1, ch0…; `link_vc_o` alternates 0, 2; one flit/cycle.
- ch0 sends a 4-flit packet (H, B, B, T) while ch1 offers a head continuously → ch1 is ungranted until the cycle after ch0's tail grant, then ch1 is granted. `link_vc_o`=0 for all 4 ch0 flits.
- No credit return, ch0 VC1 streams single flits → exactly 8 flits on `link_vc_o`=1, then `ch_ready_o[0]`=0. One `credit_valid_i` with vc=1 → exactly one more flit the next cycle.
- Credit return on link VC 3 with the counter full → `error_o[0]`=1 the next cycle, stays 1; counter stays 8 (exactly 8 further sends are possible).
- ch1 offers a body flit (head=0) with the lock free → `ch_ready_o[1]` stays 0, `error_o[1]`=1; ch0 traffic is unaffected.
- `rst` pulsed mid-packet while ch0 holds the lock with credits at 3 → next cycle: outputs 0, credits 8, lock free; a ch1 head is granted on the first post-reset cycle.
